audio_sample_fifo_ci: RTL and testbench
=======================================

Name: audio_sample_fifo_ci

Overview:
- Upstream feeder for the moving-average custom instruction.
- Buffers signed audio samples arriving from the audio core on an Avalon-ST sink.
- Hands samples to the Nios II CPU through a multicycle custom instruction. The CPU then issues each sample as dataa to the averaging stage.
- Provides pop, peek, status and clear commands, with sticky overflow/underflow flags.

Parameters:
- DATA_W, 24, audio sample width on the sink; sign-extended to 32 bits on result.
- DEPTH, 32, FIFO depth in samples; power of two, 4..1024.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- snk_data  in  DATA_W  audio sample (two's complement)
- snk_valid  in  1  sample present
- snk_ready  out  1  FIFO can accept (= !full, registered)
- clk_en  in  1  CI clock enable, active high
- start  in  1  CI start, sampled only when clk_en=1
- n  in  2  CI command: 0 POP, 1 PEEK, 2 STATUS, 3 CLEAR
- dataa  in  32  unused (reserved)
- datab  in  32  unused (reserved)
- result  out  32  CI result
- done  out  1  CI completion, one-cycle pulse

Behaviour:
- Reset (reset=0, async): rd_ptr=wr_ptr=count=0, flags cleared, result=0, done=0, snk_ready=1, FSM=IDLE. Memory contents are don't-care. Reset mid-instruction aborts it; no done is issued.
- Sink side is independent of clk_en.
  - Push when snk_valid & snk_ready: write at wr_ptr, wr_ptr wraps modulo DEPTH.
  - snk_valid & !snk_ready sets sticky ovf; the sample is not stored (the source may hold or drop it).
- CI FSM has states IDLE, EXEC, RESP. It advances only when clk_en=1 and holds when clk_en=0.
  - IDLE: start=1 latches n and moves to EXEC.
  - EXEC: act on the command using count as of this cycle.
    - POP and PEEK read mem[rd_ptr].
    - POP with count>0 also advances rd_ptr (wrap) and decrements count.
  - RESP: drive result, done=1 for exactly one cycle, then return to IDLE.
  - Latency: start at cycle T gives done at T+2 (with clk_en high throughout).
- result is held between instructions; done=0 outside RESP.
- POP/PEEK result:
  - Sample sign-extended from DATA_W to 32.
  - If count==0: result=0, set sticky udf, pointers unchanged.
- STATUS result: [31]=ovf, [30]=udf, [29]=empty, [28]=full, [27:CNT_W]=0, [CNT_W-1:0]=count. Reading status does not clear flags.
- CLEAR: rd_ptr=wr_ptr=count=0, ovf=udf=0, result=0. A push in the same EXEC cycle is discarded.
- Simultaneous push and POP in EXEC:
  - count unchanged.
  - If count was 0: the pop underflows and the pushed sample is kept (count becomes 1).
- full = (count==DEPTH); empty = (count==0).
  - snk_ready is registered from the next-state count, so it never permits a write into a full FIFO.
  - A pop from full raises snk_ready the following cycle.
- count arithmetic is unsigned CNT_W bits and never wraps.

Decomposition:
- Package audio_ci_pkg holds:
  - command enum ci_cmd_e {CMD_POP, CMD_PEEK, CMD_STATUS, CMD_CLEAR}
  - FSM enum ci_state_e {IDLE, EXEC, RESP}
  - status bit-position constants ST_OVF=31, ST_UDF=30, ST_EMPTY=29, ST_FULL=28
- One sub-module, sample_ram_dp: simple dual-port RAM (DEPTH x DATA_W, sync write, async or registered read). It infers M10K when registered.
- Pointers, count, flags and FSM live in the top module.

Test Plan:
- Reset, then STATUS → result=0x2000_0000 (empty), done at T+2, snk_ready=1.
- Push 0x000123, 0x800000, 0x7FFFFF, then POP x3 → 0x0000_0123, 0xFF80_0000, 0x007F_FFFF; STATUS count=0.
- POP on empty → result=0, then STATUS=0x6000_0000 (udf|empty); CLEAR → STATUS=0x2000_0000.
- Push 33 samples with DEPTH=32 → snk_ready=0 after the 32nd, ovf set, STATUS=0x9000_0020. One POP → snk_ready=1 next cycle, 33rd sample accepted on retry.
- PEEK twice then POP with one sample 0x000055 → all three return 0x0000_0055; final count=0.
- clk_en deasserted for 5 cycles during EXEC → done delayed 5 cycles, pushes continue.
- Reset asserted mid-POP → done never pulses, outputs return to reset values.

Source files
------------

// File: rtl/audio_ci_pkg.sv
// Shared types and constants for the audio sample FIFO custom instruction.
package audio_ci_pkg;

  typedef enum logic [1:0] {
    CMD_POP    = 2'd0,
    CMD_PEEK   = 2'd1,
    CMD_STATUS = 2'd2,
    CMD_CLEAR  = 2'd3
  } ci_cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } ci_state_e;

  localparam int unsigned ST_OVF   = 31;
  localparam int unsigned ST_UDF   = 30;
  localparam int unsigned ST_EMPTY = 29;
  localparam int unsigned ST_FULL  = 28;

endpackage

// File: rtl/audio_sample_fifo_ci_if.sv
// Avalon-ST sample sink plus Nios II multicycle custom-instruction bus.
interface audio_sample_fifo_ci_if #(
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] snk_data;
  logic              snk_valid;
  logic              snk_ready;
  logic              clk_en;
  logic              start;
  logic [1:0]        n;
  logic [31:0]       dataa;
  logic [31:0]       datab;
  logic [31:0]       result;
  logic              done;

  modport master (
    output snk_data, snk_valid, clk_en, start, n, dataa, datab,
    input  snk_ready, result, done
  );

  modport slave (
    input  snk_data, snk_valid, clk_en, start, n, dataa, datab,
    output snk_ready, result, done
  );
endinterface

// File: rtl/sample_ram_dp.sv
// Simple dual-port sample store: synchronous write, asynchronous read.
module sample_ram_dp #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/audio_sample_fifo_ci.sv
// Audio sample FIFO: Avalon-ST sink in, Nios II multicycle custom instruction out
// with pop/peek/status/clear commands and sticky overflow/underflow flags.
module audio_sample_fifo_ci
  import audio_ci_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input logic                   clk,
  input logic                   reset,
  audio_sample_fifo_ci_if.slave bus
);
  localparam int unsigned         PTR_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);

  ci_state_e         state_q, state_d;
  ci_cmd_e           cmd_q, cmd_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d, udf_q, udf_d, ready_q, ready_d;
  logic [31:0]       result_q, result_d;
  logic [DATA_W-1:0] rd_data;
  logic              push, pop, clear;

  logic unused_ci;
  assign unused_ci = ^{bus.dataa, bus.datab};

  sample_ram_dp #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk  (clk),
    .we   (push),
    .waddr(wr_ptr_q),
    .wdata(bus.snk_data),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    result_d = result_q;
    udf_d    = udf_q;
    pop      = 1'b0;
    clear    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.clk_en && bus.start) begin
          state_d = EXEC;
          cmd_d   = ci_cmd_e'(bus.n);
        end
      end
      EXEC: begin
        if (bus.clk_en) begin
          state_d = RESP;
          unique case (cmd_q)
            CMD_POP, CMD_PEEK: begin
              if (count_q == '0) begin
                result_d = '0;
                udf_d    = 1'b1;
              end else begin
                result_d = 32'($signed(rd_data));
                pop      = (cmd_q == CMD_POP);
              end
            end
            CMD_STATUS: begin
              result_d              = '0;
              result_d[ST_OVF]      = ovf_q;
              result_d[ST_UDF]      = udf_q;
              result_d[ST_EMPTY]    = (count_q == '0);
              result_d[ST_FULL]     = (count_q == FULL_CNT);
              result_d[CNT_W-1:0]   = count_q;
            end
            CMD_CLEAR: begin
              result_d = '0;
              clear    = 1'b1;
            end
            default: ;
          endcase
        end
      end
      RESP: begin
        if (bus.clk_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A push landing in the same cycle as CLEAR is dropped with the rest of the contents.
    push     = bus.snk_valid && ready_q && !clear;
    rd_ptr_d = clear ? '0 : (pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q);
    wr_ptr_d = clear ? '0 : (push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q);
    count_d  = clear ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    ovf_d    = clear ? 1'b0 : (ovf_q || (bus.snk_valid && !ready_q));
    if (clear) udf_d = 1'b0;
    ready_d  = (count_d != FULL_CNT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_POP;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  assign bus.snk_ready = ready_q;
  assign bus.result    = result_q;
  // done pulses on the cycle the FSM leaves RESP, so a clk_en stall cannot stretch it.
  assign bus.done      = bus.clk_en && (state_q == RESP);
endmodule

// File: tb/tb_audio_sample_fifo_ci.sv
// Scoreboard bench for audio_sample_fifo_ci: stimulus queues expected results and
// completion cycles, a monitor checks them whenever done is seen.
module tb_audio_sample_fifo_ci;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned DEPTH  = 32;
  localparam logic [1:0] C_POP = 2'd0, C_PEEK = 2'd1, C_STATUS = 2'd2, C_CLEAR = 2'd3;

  typedef struct {
    logic [31:0] res;
    int unsigned at;
  } exp_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc     = 0;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  exp_t        sb[$];

  audio_sample_fifo_ci_if #(.DATA_W(DATA_W)) bus ();

  audio_sample_fifo_ci #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious done", {31'd0, bus.done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("done cycle", cyc, e.at);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      check("done timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic ci(input logic [1:0] cmd, input logic [31:0] res);
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.n      = cmd;
    bus.clk_en = 1'b1;
    sb.push_back('{res, cyc + 2});
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done();
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    @(posedge clk); #1;
    bus.snk_valid = 1'b1;
    bus.snk_data  = d;
    @(posedge clk); #1;
    bus.snk_valid = 1'b0;
  endtask

  initial begin
    logic seen_done;
    bus.snk_data  = '0;
    bus.snk_valid = 1'b0;
    bus.clk_en    = 1'b1;
    bus.start     = 1'b0;
    bus.n         = 2'd0;
    bus.dataa     = '0;
    bus.datab     = '0;

    #12;
    check("reset snk_ready", {31'd0, bus.snk_ready}, 32'd1);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    ci(C_STATUS, 32'h2000_0000);

    // Sign extension of positive, most negative and most positive samples.
    push(24'h000123);
    push(24'h800000);
    push(24'h7FFFFF);
    ci(C_POP, 32'h0000_0123);
    ci(C_POP, 32'hFF80_0000);
    ci(C_POP, 32'h007F_FFFF);
    ci(C_STATUS, 32'h2000_0000);

    // Underflow is sticky until CLEAR.
    ci(C_POP, 32'h0000_0000);
    ci(C_STATUS, 32'h6000_0000);
    ci(C_CLEAR, 32'h0000_0000);
    ci(C_STATUS, 32'h2000_0000);

    // Fill to full, overflow with the 33rd, then drain through the pointer wrap.
    for (int i = 1; i <= 33; i++) begin
      push(DATA_W'(i));
      if (i == 32) check("snk_ready at full", {31'd0, bus.snk_ready}, 32'd0);
    end
    ci(C_STATUS, 32'h9000_0020);
    ci(C_POP, 32'd1);
    check("snk_ready after pop", {31'd0, bus.snk_ready}, 32'd1);
    push(DATA_W'(33));
    check("snk_ready refilled", {31'd0, bus.snk_ready}, 32'd0);
    ci(C_STATUS, 32'h9000_0020);
    for (int i = 2; i <= 33; i++) ci(C_POP, 32'(i));
    ci(C_STATUS, 32'hA000_0000);
    ci(C_CLEAR, 32'h0000_0000);
    ci(C_STATUS, 32'h2000_0000);

    // PEEK does not consume.
    push(24'h000055);
    ci(C_PEEK, 32'h0000_0055);
    ci(C_PEEK, 32'h0000_0055);
    ci(C_POP, 32'h0000_0055);
    ci(C_STATUS, 32'h2000_0000);

    // clk_en low for five cycles in EXEC; pushes keep landing meanwhile.
    push(24'h000111);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n     = C_POP;
    sb.push_back('{32'h0000_0111, cyc + 7});
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.clk_en    = 1'b0;
    bus.snk_valid = 1'b1;
    bus.snk_data  = 24'h000222;
    @(posedge clk); #1;
    bus.snk_data = 24'h000333;
    @(posedge clk); #1;
    bus.snk_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.clk_en = 1'b1;
    wait_done();
    ci(C_POP, 32'h0000_0222);
    ci(C_POP, 32'h0000_0333);
    ci(C_STATUS, 32'h2000_0000);

    // Push coinciding with a POP on empty: pop underflows, sample is kept.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n     = C_POP;
    sb.push_back('{32'h0000_0000, cyc + 2});
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.snk_valid = 1'b1;
    bus.snk_data  = 24'hFFFFFE;
    @(posedge clk); #1;
    bus.snk_valid = 1'b0;
    wait_done();
    ci(C_STATUS, 32'h4000_0001);
    ci(C_POP, 32'hFFFF_FFFE);
    ci(C_CLEAR, 32'h0000_0000);

    // Reset in the middle of a POP aborts it.
    push(24'h000077);
    ci(C_STATUS, 32'h0000_0001);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.n     = C_POP;
    @(posedge clk); #1;
    bus.start = 1'b0;
    reset     = 1'b0;
    #1;
    check("abort snk_ready", {31'd0, bus.snk_ready}, 32'd1);
    check("abort result", bus.result, 32'd0);
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_done = seen_done | bus.done;
    end
    check("abort no done", {31'd0, seen_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    ci(C_STATUS, 32'h2000_0000);

    check("scoreboard drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
